setting_bus_master: RTL and testbench
=====================================

SETTING_BUS_MASTER -- requirements
Module: setting_bus_master

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for the serial inputs (legal values 2..3).
REQ-002 The module SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port serial_enable, input, 1 bit: frame enable, active-high, asynchronous to clock.
REQ-005 The module SHALL have port serial_clock, input, 1 bit: serial bit clock, asynchronous, at most clock/8.
REQ-006 The module SHALL have port serial_data_in, input, 1 bit: serial write data, MSB first.
REQ-007 The module SHALL have port serial_data_out, output, 1 bit: serial readback data, MSB first.
REQ-008 The module SHALL have port strobe, output, 1 bit: single-cycle write strobe to the setting registers.
REQ-009 The module SHALL have port addr, output, 7 bits: setting address, valid while strobe is high and held afterwards.
REQ-010 The module SHALL have port data, output, 32 bits: setting value, valid while strobe is high and held afterwards.
REQ-011 The module SHALL have port readback_addr, output, 7 bits: address of the word being read back.
REQ-012 The module SHALL have port readback_data, input, 32 bits: readback word, combinational from readback_addr.

Function
REQ-013 serial_enable, serial_clock and serial_data_in SHALL each pass through a SYNC_STAGES flop synchronizer; all further logic SHALL use only the synchronized copies (sen, sclk, sdi).
REQ-014 An sclk rising edge SHALL be a cycle where sclk=1 and its previous-cycle value=0; a falling edge is the converse.
REQ-015 Frame format: 8 header bits (bit7 = read flag, bits6:0 = address), then 32 data bits, 40 bits in total, each sampled on an sclk rising edge.
REQ-016 State machine states: IDLE, HEADER, WR_DATA, RD_DATA, WAIT_END.
REQ-017 Transitions: IDLE->HEADER on a sen rising edge, with the bit counter cleared.
REQ-018 Transitions: HEADER->WR_DATA or RD_DATA after the 8th header bit, selected by the read flag.
REQ-019 Transitions: WR_DATA->WAIT_END after the 32nd data bit.
REQ-020 Transitions: RD_DATA->WAIT_END after the 32nd sclk falling edge.
REQ-021 Transitions: WAIT_END->IDLE when sen=0.
REQ-022 The bit counter SHALL be 6 bits; it SHALL NOT wrap, and it SHALL saturate at 40.
REQ-023 A completed write frame SHALL load addr and data from the shift registers and assert strobe for exactly one clock, in the cycle after the first cycle in which sen=0 is seen in WAIT_END.
REQ-024 The strobe SHALL occur once per frame; extra sclk edges after bit 40 SHALL be ignored and SHALL NOT alter addr or data.
REQ-025 Abort: if sen falls in HEADER, WR_DATA or RD_DATA, the FSM SHALL return to IDLE with no strobe, and addr and data SHALL keep their previous values.
REQ-026 Read: readback_addr SHALL be the 7-bit header address from the cycle after the 8th header bit until the next frame's header completes.
REQ-027 Read: readback_data SHALL be latched into the 32-bit output shift register 2 clocks after readback_addr updates.
REQ-028 Read: serial_data_out SHALL present bit31 immediately after the latch and shift left on each sclk falling edge.
REQ-029 serial_data_out SHALL be 0 outside RD_DATA.
REQ-030 A write frame SHALL never cause a read-side effect, and a read frame SHALL never assert strobe.
REQ-031 A sen rising edge in WAIT_END, with sen still 1, SHALL be ignored; a new frame requires sen to return to 0 first.
REQ-032 If a sen rising edge and an sclk rising edge coincide, the sclk edge SHALL be taken as header bit7.

Reset
REQ-033 While reset=0 on a clock edge, the module SHALL set state=IDLE, counter=0, strobe=0, addr=0, data=0, readback_addr=0, serial_data_out=0, clear the shift registers, and set synchronizer flops to 0.
REQ-034 A reset mid-frame SHALL abandon the frame without a strobe; the next sen rising edge after release SHALL start a clean frame.

Verification
REQ-035 Write frame, header 0x05, data 0xDEADBEEF, then sen falls -> one strobe pulse with addr=0x05 and data=0xDEADBEEF; strobe is 0 in all other cycles.
REQ-036 Read frame, header 0x85, model readback_data = {25'h0, readback_addr} -> readback_addr=0x05, and serial_data_out shifts out 0x00000005 MSB first on 32 falling edges; no strobe.
REQ-037 Write header 0x10, then sen drops after 20 data bits -> no strobe, and addr/data hold their prior 0x05/0xDEADBEEF.
REQ-038 Write frame with 45 sclk pulses, addr 0x7F, data 0x00000001 -> exactly one strobe, with addr=0x7F and data=0x00000001; the extra bits are ignored.
REQ-039 reset=0 asserted at bit 30 of a write frame, then released -> all outputs are 0 and there is no strobe; a following full write of 0x01/0x12345678 strobes correctly.
REQ-040 Two back-to-back writes separated by a 4-clock sen low gap -> two strobes, with the correct values for each.

Source files
------------

// File: rtl/setting_bus_master.sv
// setting_bus_master: serial-to-parallel setting bus master with 40-bit write frames and 32-bit serial readback
module setting_bus_master #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_enable,
    input  logic        serial_clock,
    input  logic        serial_data_in,
    output logic        serial_data_out,
    output logic        strobe,
    output logic [6:0]  addr,
    output logic [31:0] data,
    output logic [6:0]  readback_addr,
    input  logic [31:0] readback_data
);
    typedef enum logic [2:0] {IDLE, HEADER, WR_DATA, RD_DATA, WAIT_END} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] s_en, s_clk, s_di;
    logic sen, sclk, sdi, sen_d, sclk_d, sen_rise, sclk_rise, sclk_fall;
    logic [5:0] cnt;
    logic [38:0] sr;
    logic [31:0] out_sr;
    logic [1:0] ld;
    logic wr, take, clr, hdr_done, rd_shift, commit;
    assign sen = s_en[SYNC_STAGES-1];
    assign sclk = s_clk[SYNC_STAGES-1];
    assign sdi = s_di[SYNC_STAGES-1];
    assign sen_rise = sen & ~sen_d;
    assign sclk_rise = sclk & ~sclk_d;
    assign sclk_fall = ~sclk & sclk_d;
    assign serial_data_out = (state == RD_DATA) & out_sr[31];
    always_ff @(posedge clock) begin
        if (!reset) begin
            s_en <= '0;
            s_clk <= '0;
            s_di <= '0;
            sen_d <= 1'b0;
            sclk_d <= 1'b0;
            state <= IDLE;
        end else begin
            s_en <= {s_en[SYNC_STAGES-2:0], serial_enable};
            s_clk <= {s_clk[SYNC_STAGES-2:0], serial_clock};
            s_di <= {s_di[SYNC_STAGES-2:0], serial_data_in};
            sen_d <= sen;
            sclk_d <= sclk;
            state <= state_n;
        end
    end
    always_comb begin
        state_n = state;
        take = 1'b0;
        clr = 1'b0;
        hdr_done = 1'b0;
        rd_shift = 1'b0;
        commit = 1'b0;
        case (state)
            IDLE: if (sen_rise) begin
                state_n = HEADER;
                clr = 1'b1;
                take = sclk_rise;
            end
            HEADER: if (!sen) state_n = IDLE;
                else if (sclk_rise) begin
                    take = 1'b1;
                    if (cnt == 6'd7) begin
                        hdr_done = 1'b1;
                        state_n = sr[6] ? RD_DATA : WR_DATA;
                    end
                end
            WR_DATA: if (!sen) state_n = IDLE;
                else if (sclk_rise) begin
                    take = 1'b1;
                    if (cnt == 6'd39) state_n = WAIT_END;
                end
            RD_DATA: if (!sen) state_n = IDLE;
                else if (sclk_fall) begin
                    rd_shift = 1'b1;
                    if (cnt == 6'd39) state_n = WAIT_END;
                end
            WAIT_END: if (!sen) begin
                state_n = IDLE;
                commit = wr;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
            sr <= '0;
            wr <= 1'b0;
            strobe <= 1'b0;
            addr <= '0;
            data <= '0;
            readback_addr <= '0;
            ld <= '0;
            out_sr <= '0;
        end else begin
            strobe <= commit;
            if (commit) begin
                addr <= sr[38:32];
                data <= sr[31:0];
            end
            if (clr) begin
                cnt <= 6'(take);
                sr <= {38'b0, take & sdi};
                wr <= 1'b0;
            end else if (take || rd_shift) begin
                cnt <= (cnt == 6'd40) ? cnt : cnt + 6'd1;
                if (take) sr <= {sr[37:0], sdi};
            end
            if (hdr_done) wr <= ~sr[6];
            if (hdr_done && sr[6]) readback_addr <= {sr[5:0], sdi};
            // two-cycle delay gives the external readback mux time to settle
            ld <= {ld[0], hdr_done & sr[6]};
            if (ld[1]) out_sr <= readback_data;
            else if (rd_shift) out_sr <= {out_sr[30:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_setting_bus_master.sv
// tb_setting_bus_master: randomized frame-level checks against a transaction model of the setting bus
module tb_setting_bus_master;
    logic clock = 1'b0;
    logic reset, sen, sclk, sdi, sdo, strobe;
    logic [6:0] addr, rb_addr;
    logic [31:0] data, rb_data;
    logic [31:0] mem [128];
    logic [38:0] obs_q[$], exp_q[$];
    logic [6:0] exp_addr, exp_rb;
    logic [31:0] exp_data;
    int n_chk = 0, n_pass = 0;
    always #5 clock = ~clock;
    assign rb_data = mem[rb_addr];
    setting_bus_master #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .serial_enable(sen), .serial_clock(sclk),
        .serial_data_in(sdi), .serial_data_out(sdo), .strobe(strobe), .addr(addr),
        .data(data), .readback_addr(rb_addr), .readback_data(rb_data)
    );
    always @(negedge clock) if (strobe) obs_q.push_back({addr, data});
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask
    task automatic check_state();
        check("strobe_cnt", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("strobe_val", 64'(obs_q[i]), 64'(exp_q[i]));
        check("addr", 64'(addr), 64'(exp_addr));
        check("data", 64'(data), 64'(exp_data));
        check("rb_addr", 64'(rb_addr), 64'(exp_rb));
        obs_q.delete();
        exp_q.delete();
    endtask
    // np sclk pulses requested; the frame is cut after ab pulses by sen low or by reset
    task automatic frame(input logic [7:0] hdr, input logic [31:0] w, input int np,
                         input int ab, input bit rs, input int gap);
        logic [39:0] bits;
        logic [31:0] rw;
        int done;
        bits = {hdr, w};
        done = (ab < np) ? ab : np;
        rw = mem[hdr[6:0]];
        sen = 1'b1;
        tick(8);
        for (int i = 0; i < done; i++) begin
            sdi = (i < 40) ? bits[39-i] : 1'($urandom);
            tick(8);
            sclk = 1'b1;
            tick(8);
            check("sdo", 64'(sdo), 64'((hdr[7] && i >= 7 && i <= 38) ? rw[38-i] : 1'b0));
            sclk = 1'b0;
        end
        if (rs && done < np) begin
            reset = 1'b0;
            tick(4);
            sen = 1'b0;
            tick(4);
            reset = 1'b1;
            exp_addr = '0;
            exp_data = '0;
            exp_rb = '0;
        end else begin
            tick(8);
            sen = 1'b0;
            if (!hdr[7] && done >= 40) begin
                exp_q.push_back({hdr[6:0], w});
                exp_addr = hdr[6:0];
                exp_data = w;
            end
            if (hdr[7] && done >= 8) exp_rb = hdr[6:0];
        end
        tick(gap);
    endtask
    initial begin
        reset = 1'b0;
        sen = 1'b0;
        sclk = 1'b0;
        sdi = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_rb = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
        tick(5);
        check("rst_strobe", 64'(strobe), 64'(0));
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        check("rst_rb_addr", 64'(rb_addr), 64'(0));
        check("rst_sdo", 64'(sdo), 64'(0));
        reset = 1'b1;
        tick(4);
        frame(8'h05, 32'hDEADBEEF, 40, 99, 1'b0, 12);
        check_state();
        frame(8'h85, 32'h0, 40, 99, 1'b0, 12);
        check_state();
        frame(8'h10, 32'h0BADF00D, 40, 28, 1'b0, 12);
        check_state();
        frame(8'h7F, 32'h00000001, 45, 99, 1'b0, 12);
        check_state();
        frame(8'h22, 32'hCAFEF00D, 40, 30, 1'b1, 12);
        check("post_rst_sdo", 64'(sdo), 64'(0));
        check("post_rst_strobe", 64'(strobe), 64'(0));
        check_state();
        frame(8'h01, 32'h12345678, 40, 99, 1'b0, 12);
        check_state();
        frame(8'h11, 32'hA5A5A5A5, 40, 99, 1'b0, 4);
        frame(8'h12, 32'h5A5A5A5A, 40, 99, 1'b0, 12);
        check_state();
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int k = 0; k < 10; k++) begin
            frame(8'($urandom), $urandom, 40 + int'($urandom_range(0, 4)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : 99, 1'b0, 12);
            check_state();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
